// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions, used by both ends of the row-strobe/column-sense
// bus (this emulator and the keypad scanner).
//   kp_onecold : 2-bit row/column index -> 4-bit active-low one-cold code
//   KP_IDLE    : released level of the SWR/SWC lines
//   kp_state_e : emulator press-sequencer states
package keypad_emulator_pkg;

  localparam logic [3:0] KP_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } kp_state_e;

  // index 0..3 -> 1110, 1101, 1011, 0111
  function automatic logic [3:0] kp_onecold(input logic [1:0] idx);
    kp_onecold = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: the responder end of the row-strobe /
// column-sense interface. A key code taken over valid/ready is "pressed" for
// HOLD_CYCLES clean cycles, with BOUNCE_CYCLES of chatter at make and break,
// followed by GAP_CYCLES released cycles before the next request.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  press request present
//   req_key    key code, [3:2] row index, [1:0] column index
//   req_ready  high only in IDLE
//   SWR        row strobes from the scanner, active-low
//   SWC        column sense to the scanner, active-low, idle 4'b1111
//   busy       high in every state except IDLE
//   done       one-cycle pulse on the last GAP cycle
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int HOLD_CYCLES   = 64,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] SWR,
  output logic [3:0] SWC,
  output logic       busy,
  output logic       done
);

  localparam int MAXP = (HOLD_CYCLES > BOUNCE_CYCLES)
                      ? ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES)
                      : ((BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES);
  localparam int CW   = $clog2(MAXP) + 1;

  // Reload values; the bounce load is never used when bounce is disabled,
  // it is clamped only to keep the constant non-negative.
  localparam logic [CW-1:0] LD_HOLD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_BNC  = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LD_GAP  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  kp_state_e     state;
  logic          contact;
  logic [CW-1:0] cnt;
  logic [3:0]    key;

  // One shared down-counter, reloaded on every state change so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      contact <= 1'b0;
      cnt     <= '0;
      key     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            key     <= req_key;
            contact <= 1'b1;          // make: contact closes on the next edge
            if (BOUNCE_CYCLES > 0) begin
              state <= ST_BOUNCE_IN;
              cnt   <= LD_BNC;
            end else begin
              state <= ST_HOLD;
              cnt   <= LD_HOLD;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (cnt == '0) begin
            state   <= ST_HOLD;
            cnt     <= LD_HOLD;
            contact <= 1'b1;
          end else begin
            cnt     <= cnt - ONE;
            contact <= ~contact;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            contact <= 1'b0;          // break chatter starts open
            if (BOUNCE_CYCLES > 0) begin
              state <= ST_BOUNCE_OUT;
              cnt   <= LD_BNC;
            end else begin
              state <= ST_GAP;
              cnt   <= LD_GAP;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_BOUNCE_OUT: begin
          if (cnt == '0) begin
            state   <= ST_GAP;
            cnt     <= LD_GAP;
            contact <= 1'b0;
          end else begin
            cnt     <= cnt - ONE;
            contact <= ~contact;
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - ONE;
        end
        default: begin
          state   <= ST_IDLE;
          contact <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  // Status decodes straight from registered state, no combinational input path.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_GAP) && (cnt == '0);

  // Column drive follows SWR in the same cycle so the scanner sees the key in
  // the very cycle it strobes the row; other low row bits do not mask it.
  always_comb begin
    SWC = KP_IDLE;
    if (contact && !SWR[key[3:2]]) SWC = kp_onecold(key[1:0]);
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int HA = 6, BA = 4, GA = 3;   // dut 0: with bounce
  localparam int HB = 8, BB = 0, GB = 2;   // dut 1: bounce disabled
  localparam int TA = 2*BA + HA + GA;      // 17
  localparam int TB = 2*BB + HB + GB;      // 10

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] swr;
  logic       rv  [2];
  logic [3:0] rk  [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       dn  [2];
  logic [3:0] swc [2];

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  // model: cycle offset within the current press (-1 = idle) and latched key
  int       mk   [2] = '{-1, -1};
  logic [3:0] mkey [2] = '{4'h0, 4'h0};

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(HA), .BOUNCE_CYCLES(BA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_key(rk[0]), .req_ready(rdy[0]),
    .SWR(swr), .SWC(swc[0]), .busy(bsy[0]), .done(dn[0]));

  keypad_emulator #(.HOLD_CYCLES(HB), .BOUNCE_CYCLES(BB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_key(rk[1]), .req_ready(rdy[1]),
    .SWR(swr), .SWC(swc[1]), .busy(bsy[1]), .done(dn[1]));

  function automatic int tot(int i);   return (i == 0) ? TA : TB; endfunction
  function automatic int bnc(int i);   return (i == 0) ? BA : BB; endfunction
  function automatic int hld(int i);   return (i == 0) ? HA : HB; endfunction

  function automatic logic [3:0] code(int idx);
    return 4'hF ^ (4'h1 << idx);
  endfunction

  // contact level k cycles after acceptance, straight from the press profile
  function automatic logic m_contact(int k, int b, int h);
    if (k < 0)         return 1'b0;
    if (k < b)         return (k % 2) == 0;
    if (k < b + h)     return 1'b1;
    if (k < 2*b + h)   return ((k - b - h) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)              mk[i] <= -1;
      else if (mk[i] >= 0)  mk[i] <= (mk[i] == tot(i) - 1) ? -1 : mk[i] + 1;
      else if (rv[i]) begin
        mk[i]   <= 0;
        mkey[i] <= rk[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] e;
        e = 4'hF;
        if (m_contact(mk[i], bnc(i), hld(i)) && !swr[mkey[i][3:2]]) e = code(int'(mkey[i][1:0]));
        chk($sformatf("model swc%0d", i), swc[i], e);
        chk($sformatf("model ready%0d", i), {3'b0, rdy[i]}, {3'b0, mk[i] < 0});
        chk($sformatf("model busy%0d", i), {3'b0, bsy[i]}, {3'b0, mk[i] >= 0});
        chk($sformatf("model done%0d", i), {3'b0, dn[i]}, {3'b0, mk[i] == tot(i) - 1});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!rdy[i] && n < 100) begin tick(); n++; end
    tests++;
    if (!rdy[i]) begin
      fails++;
      $display("FAIL wait_ready%0d: got busy want ready after 100 cycles", i);
    end
  endtask

  // bounce-on profile of key 1111 with SWR = 0111, offsets 0..16
  logic [3:0] prof_a [TA] = '{4'h7, 4'hF, 4'h7, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
                              4'h7, 4'hF, 4'h7, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF};

  initial begin
    int n, dcount;
    logic seen_idle;
    logic [3:0] found;

    rst = 1'b1; swr = 4'hF;
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rk[i] = 4'h0; end
    tick(); tick();
    chk_on = 1'b1;
    rst = 1'b0; swr = 4'b1110;
    tick();
    chk("reset swc", swc[1], 4'b1111);
    chk("reset ready", {3'b0, rdy[1]}, 4'd1);
    chk("reset busy", {3'b0, bsy[1]}, 4'd0);
    chk("reset done", {3'b0, dn[1]}, 4'd0);

    // no-bounce press of key 0110 (row 1, col 2)
    rv[1] = 1'b1; rk[1] = 4'b0110;
    tick();
    rv[1] = 1'b0;
    for (int j = 0; j < HB; j++) begin
      swr = (j % 2) ? 4'b1110 : 4'b1101;
      #1;
      chk("hold swc", swc[1], (j % 2) ? 4'b1111 : 4'b1011);
      tick();
    end
    dcount = 0;
    for (int j = 0; j < 4; j++) begin
      if (dn[1]) dcount++;
      tick();
    end
    chk("done pulses", 4'(dcount), 4'd1);
    chk("ready after gap", {3'b0, rdy[1]}, 4'd1);

    // bounce profile, key 1111 with SWR 0111
    swr = 4'b0111; rv[0] = 1'b1; rk[0] = 4'hF;
    tick();
    rv[0] = 1'b0;
    for (int k = 0; k < TA; k++) begin
      chk($sformatf("bounce k%0d", k), swc[0], prof_a[k]);
      if (k == TA - 1) chk("bounce done", {3'b0, dn[0]}, 4'd1);
      tick();
    end

    // reset in the middle of HOLD, key 0001 (row 0, col 1)
    swr = 4'b1110; rv[1] = 1'b1; rk[1] = 4'b0001;
    tick();
    rv[1] = 1'b0;
    tick(); tick(); tick();
    chk("pre-reset swc", swc[1], 4'b1101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post-reset swc", swc[1], 4'b1111);
    chk("post-reset busy", {3'b0, bsy[1]}, 4'd0);
    chk("post-reset done", {3'b0, dn[1]}, 4'd0);
    tick();

    // held-off request: second key accepted only after the first completes
    rv[0] = 1'b1; rk[0] = 4'b0011;
    tick();
    rk[0] = 4'b1000;
    n = 0; seen_idle = 1'b0;
    while (n < 40) begin
      tick(); n++;
      if (!bsy[0]) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    rv[0] = 1'b0;
    chk("second accept offset", 4'(n), 4'(TA + 1));
    swr = 4'b1011;
    #1;
    chk("second key swc", swc[0], 4'b1110);
    wait_ready(0);

    // loopback scan of every key on the no-bounce unit
    for (int key = 0; key < 16; key++) begin
      wait_ready(1);
      rv[1] = 1'b1; rk[1] = 4'(key);
      tick();
      rv[1] = 1'b0;
      found = 4'hF;
      for (int c = 0; c < HB; c++) begin
        swr = code(c % 4);
        #1;
        for (int b = 0; b < 4; b++)
          if (swc[1] == code(b)) found = {2'(c % 4), 2'(b)};
        tick();
      end
      chk($sformatf("scan key%0d", key), found, 4'(key));
    end
    wait_ready(1);

    // random traffic, checked every cycle by the model compare
    for (int c = 0; c < 2500; c++) begin
      swr = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        rk[i] = 4'($urandom);
      end
      tick();
    end
    rst = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
    tick(); tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
